// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared types and default sizing for the SRAM FIFO controller
package sram_fifo_pkg;

   typedef enum logic [1:0] {
      PRE  = 2'd0,
      RST  = 2'd1,
      POST = 2'd2,
      RUN  = 2'd3
   } ctrl_state_e;

   localparam int unsigned SRAM_FIFO_DEPTH = 512;
   localparam int unsigned SRAM_FIFO_PRE   = 4;
   localparam int unsigned SRAM_FIFO_RST   = 5;
   localparam int unsigned SRAM_FIFO_POST  = 5;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - reset sequencer, enable gating and occupancy count for the block-RAM FIFO macro
// Optional sticky error reporting is built when SRAM_FIFO_ERR_EN is defined.
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int unsigned DEPTH       = SRAM_FIFO_DEPTH,
   parameter int unsigned PRE_CYCLES  = SRAM_FIFO_PRE,
   parameter int unsigned RST_CYCLES  = SRAM_FIFO_RST,
   parameter int unsigned POST_CYCLES = SRAM_FIFO_POST,
   parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] usage_o,
   output logic             err_o,
   input  logic             err_clr_i,
   output logic             fifo_rst_o,
   output logic             fifo_wren_o,
   output logic             fifo_rden_o,
   input  logic             fifo_full_i,
   input  logic             fifo_empty_i,
   input  logic             fifo_wrerr_i,
   input  logic             fifo_rderr_i
);

   localparam int unsigned CYC_MAX_A = (PRE_CYCLES > RST_CYCLES) ? PRE_CYCLES : RST_CYCLES;
   localparam int unsigned CYC_MAX   = (CYC_MAX_A > POST_CYCLES) ? CYC_MAX_A : POST_CYCLES;
   localparam int unsigned CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   ctrl_state_e      state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] usage_q, usage_d;
   logic             run;
   logic             wren, rden;

   assign run     = (state_q == RUN);
   assign ready_o = run;
   assign full_o  = ~run | fifo_full_i;
   assign empty_o = ~run | fifo_empty_i;
   assign usage_o = usage_q;

   // Flush takes priority: a push or pop in the flush cycle never reaches the macro.
   assign wren        = push_i & ~full_o  & ~flush_i;
   assign rden        = pop_i  & ~empty_o & ~flush_i;
   assign fifo_wren_o = wren;
   assign fifo_rden_o = rden;
   assign fifo_rst_o  = (state_q == RST);

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      usage_d = usage_q;
      case (state_q)
         PRE: begin
            if (cyc_q == '0) begin
               state_d = RST;
               cyc_d   = CYC_W'(RST_CYCLES - 1);
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         RST: begin
            if (cyc_q == '0) begin
               state_d = POST;
               cyc_d   = CYC_W'(POST_CYCLES - 1);
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         POST: begin
            if (cyc_q == '0) begin
               state_d = RUN;
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         RUN: begin
            if (flush_i) begin
               state_d = PRE;
               cyc_d   = CYC_W'(PRE_CYCLES - 1);
               usage_d = '0;
            end else if (wren && !rden && usage_q != DEPTH_C) begin
               usage_d = usage_q + CNT_W'(1);
            end else if (rden && !wren && usage_q != '0) begin
               usage_d = usage_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = RST;
            cyc_d   = CYC_W'(RST_CYCLES - 1);
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RST;
         cyc_q   <= CYC_W'(RST_CYCLES - 1);
         usage_q <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         usage_q <= usage_d;
      end
   end

`ifdef SRAM_FIFO_ERR_EN
   logic err_q, err_d, err_set;

   // Over/underflow means the count disagrees with what the macro accepted.
   assign err_set = (run & (fifo_wrerr_i | fifo_rderr_i |
                            (push_i & fifo_full_i) | (pop_i & fifo_empty_i)))
                  | (wren & ~rden & (usage_q == DEPTH_C))
                  | (rden & ~wren & (usage_q == '0));

   always_comb begin
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_err_inputs;

   assign unused_err_inputs = ^{err_clr_i, fifo_wrerr_i, fifo_rderr_i};
   assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - randomized and directed checks of sram_fifo_ctrl against a timeline model
module tb_sram_fifo_ctrl;
   import sram_fifo_pkg::*;

   localparam int DEPTH = 512;
   localparam int CNT_W = 10;
`ifdef SRAM_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_ni;
   logic             flush_i, push_i, pop_i, err_clr_i;
   logic             fifo_full_i, fifo_empty_i, fifo_wrerr_i, fifo_rderr_i;
   logic             ready_o, full_o, empty_o, err_o;
   logic             fifo_rst_o, fifo_wren_o, fifo_rden_o;
   logic [CNT_W-1:0] usage_o;

   sram_fifo_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .push_i       (push_i),
      .pop_i        (pop_i),
      .ready_o      (ready_o),
      .full_o       (full_o),
      .empty_o      (empty_o),
      .usage_o      (usage_o),
      .err_o        (err_o),
      .err_clr_i    (err_clr_i),
      .fifo_rst_o   (fifo_rst_o),
      .fifo_wren_o  (fifo_wren_o),
      .fifo_rden_o  (fifo_rden_o),
      .fifo_full_i  (fifo_full_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_wrerr_i (fifo_wrerr_i),
      .fifo_rderr_i (fifo_rderr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timeline position: 0..3 PRE, 4..8 RST, 9..13 POST, 14 RUN.
   int idx;
   int cnt;
   int mc;
   bit err_m;
   bit known;
   bit ovr_empty;
   int n_chk;
   int n_err;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_flags();
      fifo_full_i  = (mc >= DEPTH);
      fifo_empty_i = (mc == 0) && !ovr_empty;
   endtask

   task automatic sample();
      bit run, full_e, empty_e, wr_e, rd_e, set_e;
      @(negedge clk);
      run     = (idx == 14);
      full_e  = !run || fifo_full_i;
      empty_e = !run || fifo_empty_i;
      wr_e    = push_i && !full_e && !flush_i;
      rd_e    = pop_i && !empty_e && !flush_i;
      if (known) begin
         chk("ready",    int'(ready_o),     int'(run));
         chk("full",     int'(full_o),      int'(full_e));
         chk("empty",    int'(empty_o),     int'(empty_e));
         chk("fifo_rst", int'(fifo_rst_o),  int'(idx >= 4 && idx <= 8));
         chk("wren",     int'(fifo_wren_o), int'(wr_e));
         chk("rden",     int'(fifo_rden_o), int'(rd_e));
         chk("usage",    int'(usage_o),     cnt);
         chk("err",      int'(err_o),       int'(err_m));
      end
      if (!rst_ni) begin
         idx = 4; cnt = 0; mc = 0; err_m = 1'b0; known = 1'b1;
      end else if (known) begin
         set_e = (run && (fifo_wrerr_i || fifo_rderr_i || (push_i && full_e) || (pop_i && empty_e)))
               || (wr_e && !rd_e && cnt == DEPTH) || (rd_e && !wr_e && cnt == 0);
         if (ERR_EN) err_m = set_e ? 1'b1 : (err_clr_i ? 1'b0 : err_m);
         if (wr_e && mc < DEPTH) mc++;
         if (rd_e && mc > 0) mc--;
         if (!run) idx++;
         else if (flush_i) begin idx = 0; cnt = 0; end
         else if (wr_e && !rd_e && cnt < DEPTH) cnt++;
         else if (rd_e && !wr_e && cnt > 0) cnt--;
         if (idx >= 4 && idx <= 8) mc = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_flags();
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic release_check(input string tag);
      for (int c = 0; c <= 10; c++) begin
         sample();
         chk({tag, " fifo_rst lit"}, int'(fifo_rst_o), int'(c < 5));
         chk({tag, " ready lit"}, int'(ready_o), int'(c >= 10));
         tick();
      end
   endtask

   initial begin
      n_chk = 0; n_err = 0; known = 1'b0; ovr_empty = 1'b0;
      idx = 4; cnt = 0; mc = 0; err_m = 1'b0;
      rst_ni = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; err_clr_i = 1'b0;
      fifo_wrerr_i = 1'b0; fifo_rderr_i = 1'b0;
      drive_flags();
      #1;
      repeat (3) step();
      rst_ni = 1'b1;
      release_check("release");
      chk("release usage lit", int'(usage_o), 0);

      // Three pushes then one pop.
      push_i = 1'b1;
      sample(); chk("push1 wren lit", int'(fifo_wren_o), 1); chk("u0 lit", int'(usage_o), 0); tick();
      sample(); chk("u1 lit", int'(usage_o), 1); tick();
      sample(); chk("u2 lit", int'(usage_o), 2); tick();
      push_i = 1'b0; pop_i = 1'b1;
      sample(); chk("u3 lit", int'(usage_o), 3); chk("pop rden lit", int'(fifo_rden_o), 1); tick();
      pop_i = 1'b0;
      sample(); chk("u2b lit", int'(usage_o), 2); tick();

      // Simultaneous push and pop at usage 5.
      push_i = 1'b1;
      repeat (3) step();
      pop_i = 1'b1;
      sample();
      chk("both u5 lit", int'(usage_o), 5);
      chk("both wren lit", int'(fifo_wren_o), 1);
      chk("both rden lit", int'(fifo_rden_o), 1);
      tick();
      pop_i = 1'b0;
      sample(); chk("both keep5 lit", int'(usage_o), 5); tick();

      // Fill to DEPTH, then push into a full macro.
      repeat (DEPTH - 5) step();
      sample();
      chk("fill u512 lit", int'(usage_o), DEPTH);
      chk("fill wren lit", int'(fifo_wren_o), 0);
      chk("fill full lit", int'(full_o), 1);
      tick();
      push_i = 1'b0;
      sample();
      chk("fill keep512 lit", int'(usage_o), DEPTH);
      chk("fill err lit", int'(err_o), int'(ERR_EN));
      tick();
      err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
      sample(); chk("clr err lit", int'(err_o), 0); tick();

      // Flush with push; a second flush in PRE must not extend the sequence.
      flush_i = 1'b1; push_i = 1'b1;
      sample(); chk("flush wren lit", int'(fifo_wren_o), 0); tick();
      push_i = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         flush_i = (k == 2);
         sample();
         if (k == 1) begin
            chk("flush usage lit", int'(usage_o), 0);
            chk("flush ready lit", int'(ready_o), 0);
         end
         chk("flush fifo_rst lit", int'(fifo_rst_o), int'(k >= 5 && k <= 9));
         chk("flush ready seq lit", int'(ready_o), int'(k == 15));
         tick();
      end
      flush_i = 1'b0;

      // Read-error pulse, clear, then coincident set and clear.
      fifo_rderr_i = 1'b1; step(); fifo_rderr_i = 1'b0;
      sample(); chk("rderr set lit", int'(err_o), int'(ERR_EN)); tick();
      err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
      sample(); chk("rderr clr lit", int'(err_o), 0); tick();
      fifo_rderr_i = 1'b1; err_clr_i = 1'b1; step();
      fifo_rderr_i = 1'b0; err_clr_i = 1'b0;
      sample(); chk("set wins lit", int'(err_o), int'(ERR_EN)); tick();
      err_clr_i = 1'b1; step(); err_clr_i = 1'b0;

      // Underflow: macro claims data while the count is zero.
      ovr_empty = 1'b1; drive_flags(); pop_i = 1'b1;
      sample(); chk("uflow rden lit", int'(fifo_rden_o), 1); tick();
      pop_i = 1'b0; ovr_empty = 1'b0; drive_flags();
      sample();
      chk("uflow usage lit", int'(usage_o), 0);
      chk("uflow err lit", int'(err_o), int'(ERR_EN));
      tick();
      err_clr_i = 1'b1; step(); err_clr_i = 1'b0;

      // Reset in the middle of a flush sequence.
      flush_i = 1'b1; step(); flush_i = 1'b0;
      repeat (6) step();
      rst_ni = 1'b0; step(); rst_ni = 1'b1;
      release_check("midrst");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         push_i       = ($urandom_range(99) < 55);
         pop_i        = ($urandom_range(99) < 45);
         flush_i      = ($urandom_range(249) == 0);
         err_clr_i    = ($urandom_range(39) == 0);
         fifo_wrerr_i = ($urandom_range(149) == 0);
         fifo_rderr_i = ($urandom_range(149) == 0);
         rst_ni       = ($urandom_range(999) != 0);
         step();
      end
      rst_ni = 1'b1; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
      err_clr_i = 1'b0; fifo_wrerr_i = 1'b0; fifo_rderr_i = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
